// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780-style LCD responder: command codes,
// DDRAM bases, error flag positions, controller state and cursor stepping.
package lcd_pkg;

   localparam logic [7:0] CMD_CLEAR      = 8'h01;
   localparam logic [7:0] CMD_HOME       = 8'h02;
   localparam logic [7:0] CMD_ENTRY_INC  = 8'h06;
   localparam logic [7:0] CMD_DISPLAY_ON = 8'h0C;
   localparam logic [7:0] CMD_FUNC_SET   = 8'h38;

   localparam logic [7:0] DDRAM_LINE1 = 8'h80;
   localparam logic [7:0] DDRAM_LINE2 = 8'hC0;

   localparam logic [7:0] SPACE = 8'h20;

   localparam int ERR_BUSY  = 0;
   localparam int ERR_PULSE = 1;
   localparam int ERR_ADDR  = 2;
   localparam int ERR_RW    = 3;

   typedef enum logic [1:0] {
      S_POWERUP,
      S_IDLE,
      S_EXEC,
      S_CLEAR
   } lcd_state_t;

   // Cursor moves one position and wraps naturally within the 32-entry buffer.
   function automatic logic [4:0] step_cursor(input logic [4:0] cur, input logic inc);
      return inc ? cur + 5'd1 : cur - 5'd1;
   endfunction

endpackage

// File: rtl/lcd_responder_if.sv
// LCD writer bus: 8-bit write-only HD44780 style bus driven by the LCD writer.
interface lcd_responder_if;
   logic [7:0] lcd_data;
   logic       lcd_rs;
   logic       lcd_rw;
   logic       lcd_e;

   modport master (output lcd_data, output lcd_rs, output lcd_rw, output lcd_e);
   modport slave  (input  lcd_data, input  lcd_rs, input  lcd_rw, input  lcd_e);
endinterface

// File: rtl/lcd_ddram.sv
// 32x8 display buffer: one synchronous write port shared by data writes and
// the clear sequencer, one registered read port.
module lcd_ddram (
   input  logic       clk,
   input  logic       rst,
   input  logic       we,
   input  logic [4:0] wr_addr,
   input  logic [7:0] wr_data,
   input  logic [4:0] rd_addr,
   output logic [7:0] rd_data
);

   logic [7:0] mem [32];

   // Store one character per cycle when the write port is enabled.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[wr_addr] <= wr_data;
      end
   end

   // Registered read; cleared on reset so the output is defined before any fill.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_data <= '0;
      end else begin
         rd_data <= mem[rd_addr];
      end
   end

endmodule

// File: rtl/lcd_responder.sv
// HD44780-style bus responder: latches the bus on each E falling edge,
// decodes commands and data into a 32-character buffer, models busy time
// and records protocol violations as sticky error flags.
module lcd_responder
   import lcd_pkg::*;
#(
   parameter int BUSY_STD     = 2000,
   parameter int BUSY_CLR     = 80000,
   parameter int BUSY_POWERUP = 2000000,
   parameter int MIN_PULSE    = 12
) (
   input  logic                  clk,
   input  logic                  rst,
   lcd_responder_if.slave        bus,
   input  logic [4:0]            rd_addr,
   output logic [7:0]            rd_char,
   output logic [4:0]            cursor,
   output logic                  busy,
   output logic                  display_on,
   output logic                  initialized,
   output logic                  frame_done,
   input  logic                  err_clr,
   output logic [3:0]            err
);

   localparam int CNT_MAX = (BUSY_POWERUP > BUSY_CLR) ?
                            ((BUSY_POWERUP > BUSY_STD) ? BUSY_POWERUP : BUSY_STD) :
                            ((BUSY_CLR > BUSY_STD) ? BUSY_CLR : BUSY_STD);
   localparam int CNT_W = $clog2(CNT_MAX + 1);
   localparam logic [7:0] MIN_PULSE_W = 8'(MIN_PULSE);

   lcd_state_t       state;
   logic [CNT_W-1:0] busy_cnt;
   logic [5:0]       fill_idx;
   logic             inc;

   logic       e_q;
   logic [7:0] data_q;
   logic       rs_q;
   logic       rw_q;
   logic [7:0] hi_cnt;
   logic       fall;

   logic       accept;
   logic       is_data;
   logic       cmd_clear;
   logic       cmd_home;
   logic       cmd_entry;
   logic       cmd_display;
   logic       cmd_func;
   logic       cmd_addr;
   logic [4:0] new_addr;
   logic [3:0] new_err;

   logic       fill_we;
   logic       mem_we;
   logic [4:0] mem_addr;
   logic [7:0] mem_data;

   assign fall = e_q & ~bus.lcd_e;

   // Track E, capture the bus while E is high and count the high width.
   always_ff @(posedge clk) begin
      if (rst) begin
         e_q    <= 1'b0;
         data_q <= '0;
         rs_q   <= 1'b0;
         rw_q   <= 1'b0;
         hi_cnt <= '0;
      end else begin
         e_q <= bus.lcd_e;
         if (bus.lcd_e) begin
            data_q <= bus.lcd_data;
            rs_q   <= bus.lcd_rs;
            rw_q   <= bus.lcd_rw;
            if (hi_cnt != 8'hFF) begin
               hi_cnt <= hi_cnt + 8'd1;
            end
         end else begin
            hi_cnt <= '0;
         end
      end
   end

   // Qualify the falling edge and decode the latched command or data byte.
   always_comb begin
      accept      = 1'b0;
      is_data     = 1'b0;
      cmd_clear   = 1'b0;
      cmd_home    = 1'b0;
      cmd_entry   = 1'b0;
      cmd_display = 1'b0;
      cmd_func    = 1'b0;
      cmd_addr    = 1'b0;
      new_addr    = '0;
      new_err     = '0;
      if (fall) begin
         if (rw_q) begin
            new_err[ERR_RW] = 1'b1;
         end else if (busy) begin
            new_err[ERR_BUSY] = 1'b1;
         end else begin
            accept = 1'b1;
            if (hi_cnt < MIN_PULSE_W) begin
               new_err[ERR_PULSE] = 1'b1;
            end
         end
      end
      if (accept) begin
         if (rs_q) begin
            is_data = 1'b1;
         end else begin
            casez (data_q)
               8'b1???????: begin
                  if (data_q[6:4] == 3'b000) begin
                     cmd_addr = 1'b1;
                     new_addr = {1'b0, data_q[3:0]};
                  end else if (data_q[6:4] == 3'b100) begin
                     cmd_addr = 1'b1;
                     new_addr = {1'b1, data_q[3:0]};
                  end else begin
                     new_err[ERR_ADDR] = 1'b1;
                  end
               end
               8'b001?????: cmd_func    = 1'b1;
               8'b00001???: cmd_display = 1'b1;
               8'b000001??: cmd_entry   = 1'b1;
               8'b0000001?: cmd_home    = 1'b1;
               8'b00000001: cmd_clear   = 1'b1;
               default: begin
               end
            endcase
         end
      end
   end

   // Buffer write port: the space-fill sequencer owns it while it runs.
   always_comb begin
      fill_we  = ((state == S_POWERUP) || (state == S_CLEAR)) && !fill_idx[5];
      mem_we   = !rst && (fill_we || is_data);
      mem_addr = fill_we ? fill_idx[4:0] : cursor;
      mem_data = fill_we ? SPACE : data_q;
   end

   lcd_ddram u_ddram (
      .clk     (clk),
      .rst     (rst),
      .we      (mem_we),
      .wr_addr (mem_addr),
      .wr_data (mem_data),
      .rd_addr (rd_addr),
      .rd_data (rd_char)
   );

   // Controller state, busy timing, cursor/mode registers and sticky errors.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_POWERUP;
         busy        <= 1'b1;
         busy_cnt    <= CNT_W'(BUSY_POWERUP - 1);
         fill_idx    <= '0;
         cursor      <= '0;
         inc         <= 1'b1;
         display_on  <= 1'b0;
         initialized <= 1'b0;
         err         <= '0;
         frame_done  <= 1'b0;
      end else begin
         err        <= (err_clr ? 4'b0000 : err) | new_err;
         frame_done <= is_data && (cursor == 5'd31);
         if (fill_we) begin
            fill_idx <= fill_idx + 6'd1;
         end
         case (state)
            S_IDLE: begin
               if (accept) begin
                  busy <= 1'b1;
                  if (cmd_clear) begin
                     state    <= S_CLEAR;
                     fill_idx <= '0;
                     busy_cnt <= CNT_W'(BUSY_CLR - 1);
                  end else if (cmd_home) begin
                     state    <= S_EXEC;
                     busy_cnt <= CNT_W'(BUSY_CLR - 1);
                  end else begin
                     state    <= S_EXEC;
                     busy_cnt <= CNT_W'(BUSY_STD - 1);
                  end
               end
            end
            default: begin
               if (busy_cnt == '0) begin
                  state <= S_IDLE;
                  busy  <= 1'b0;
               end else begin
                  busy_cnt <= busy_cnt - 1'b1;
               end
            end
         endcase
         if (is_data) begin
            cursor <= step_cursor(cursor, inc);
         end
         if (cmd_clear) begin
            cursor <= '0;
            inc    <= 1'b1;
         end
         if (cmd_home) begin
            cursor <= '0;
         end
         if (cmd_entry) begin
            inc <= data_q[1];
         end
         if (cmd_display) begin
            display_on <= data_q[2];
         end
         if (cmd_func) begin
            initialized <= 1'b1;
         end
         if (cmd_addr) begin
            cursor <= new_addr;
         end
      end
   end

endmodule

// File: tb/tb_lcd_responder.sv
// Self-checking bench for lcd_responder: drives writer-style bus cycles,
// keeps a model of the display buffer and a scoreboard of expected writes.
module tb_lcd_responder;
   import lcd_pkg::*;

   localparam int T_STD = 40;
   localparam int T_CLR = 200;
   localparam int T_PWR = 300;
   localparam int T_MIN = 12;

   typedef struct {
      int         idx;
      logic [7:0] ch;
   } sb_entry_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [4:0] rd_addr;
   logic [7:0] rd_char;
   logic [4:0] cursor;
   logic       busy;
   logic       display_on;
   logic       initialized;
   logic       frame_done;
   logic       err_clr;
   logic [3:0] err;

   int         n_checks = 0;
   int         n_pass = 0;
   int         frame_cnt = 0;
   logic [7:0] exp_mem [32];
   logic [4:0] exp_cursor;
   logic       exp_inc;
   sb_entry_t  sb_q [$];

   lcd_responder_if bus ();

   lcd_responder #(
      .BUSY_STD     (T_STD),
      .BUSY_CLR     (T_CLR),
      .BUSY_POWERUP (T_PWR),
      .MIN_PULSE    (T_MIN)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .bus         (bus),
      .rd_addr     (rd_addr),
      .rd_char     (rd_char),
      .cursor      (cursor),
      .busy        (busy),
      .display_on  (display_on),
      .initialized (initialized),
      .frame_done  (frame_done),
      .err_clr     (err_clr),
      .err         (err)
   );

   // 10 ns clock.
   always #5 clk = ~clk;

   // Count frame_done pulses, sampled away from the active edge.
   always @(negedge clk) begin
      if (frame_done === 1'b1) frame_cnt++;
   end

   // Global watchdog so a stuck run still ends.
   initial begin
      #3000000;
      $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "[TB] watchdog");
   end

   task automatic wait_idle();
      int n = 0;
      while (busy === 1'b1 && n < 5000) begin
         @(negedge clk);
         n++;
      end
      n_checks++;
      if (busy !== 1'b0) $display("[TB] FAIL wait_idle: busy=%b after %0d cycles, required 0", busy, n);
      else n_pass++;
   endtask

   task automatic xfer(input logic rs, input logic rw, input logic [7:0] d, input int hi,
                       output logic fd, output logic bz);
      @(negedge clk);
      bus.lcd_rs   = rs;
      bus.lcd_rw   = rw;
      bus.lcd_data = d;
      @(negedge clk);
      bus.lcd_e = 1'b1;
      repeat (hi) @(negedge clk);
      bus.lcd_e = 1'b0;
      @(negedge clk);
      fd = frame_done;
      bz = busy;
      bus.lcd_rw = 1'b0;
   endtask

   task automatic put_cmd(input logic [7:0] c);
      logic fd, bz;
      xfer(1'b0, 1'b0, c, 50, fd, bz);
      wait_idle();
   endtask

   task automatic put_char(input logic [7:0] c, input int hi, output logic fd);
      logic bz;
      sb_entry_t e;
      xfer(1'b1, 1'b0, c, hi, fd, bz);
      e.idx = int'(exp_cursor);
      e.ch  = c;
      sb_q.push_back(e);
      exp_mem[exp_cursor] = c;
      exp_cursor = exp_inc ? exp_cursor + 5'd1 : exp_cursor - 5'd1;
      wait_idle();
   endtask

   task automatic read_char(input int idx, output logic [7:0] v);
      @(negedge clk);
      rd_addr = 5'(idx);
      @(negedge clk);
      v = rd_char;
   endtask

   task automatic pulse_err_clr();
      @(negedge clk);
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.lcd_e = 1'b0;
      bus.lcd_rs = 1'b0;
      bus.lcd_rw = 1'b0;
      bus.lcd_data = 8'h00;
      err_clr = 1'b0;
      rd_addr = 5'd0;
      repeat (3) @(negedge clk);
      n_checks++; if (busy !== 1'b1) $display("[TB] FAIL reset_busy: got %b, required 1", busy); else n_pass++;
      n_checks++; if (cursor !== 5'd0) $display("[TB] FAIL reset_cursor: got %0d, required 0", cursor); else n_pass++;
      n_checks++; if (display_on !== 1'b0) $display("[TB] FAIL reset_display_on: got %b, required 0", display_on); else n_pass++;
      n_checks++; if (initialized !== 1'b0) $display("[TB] FAIL reset_initialized: got %b, required 0", initialized); else n_pass++;
      n_checks++; if (err !== 4'h0) $display("[TB] FAIL reset_err: got %b, required 0000", err); else n_pass++;
      n_checks++; if (frame_done !== 1'b0) $display("[TB] FAIL reset_frame_done: got %b, required 0", frame_done); else n_pass++;
      n_checks++; if (rd_char !== 8'h00) $display("[TB] FAIL reset_rd_char: got %h, required 00", rd_char); else n_pass++;
      rst = 1'b0;
      for (int i = 0; i < 32; i++) exp_mem[i] = SPACE;
      exp_cursor = 5'd0;
      exp_inc = 1'b1;
      wait_idle();
   endtask

   task automatic test_init();
      logic [7:0] v;
      put_cmd(CMD_FUNC_SET);
      put_cmd(CMD_DISPLAY_ON);
      put_cmd(CMD_CLEAR);
      put_cmd(CMD_ENTRY_INC);
      n_checks++; if (err !== 4'h0) $display("[TB] FAIL init_err: got %b, required 0000", err); else n_pass++;
      n_checks++; if (initialized !== 1'b1) $display("[TB] FAIL init_initialized: got %b, required 1", initialized); else n_pass++;
      n_checks++; if (display_on !== 1'b1) $display("[TB] FAIL init_display_on: got %b, required 1", display_on); else n_pass++;
      n_checks++; if (cursor !== exp_cursor) $display("[TB] FAIL init_cursor: got %0d, required %0d", cursor, exp_cursor); else n_pass++;
      for (int i = 0; i < 32; i++) begin
         read_char(i, v);
         n_checks++;
         if (v !== exp_mem[i]) $display("[TB] FAIL init_buffer[%0d]: got %h, required %h", i, v, exp_mem[i]);
         else n_pass++;
      end
   endtask

   task automatic test_frame();
      string      l1 = "LOAD";
      string      l2 = "ABCDEFGHIJ+00042";
      logic       fd;
      logic [7:0] v;
      int         f0;
      sb_entry_t  e;
      put_cmd(DDRAM_LINE1);
      exp_cursor = 5'd0;
      for (int i = 0; i < 4; i++) put_char(l1[i], 50, fd);
      put_cmd(DDRAM_LINE2);
      exp_cursor = 5'd16;
      f0 = frame_cnt;
      for (int i = 0; i < 16; i++) put_char(l2[i], 50, fd);
      n_checks++; if (fd !== 1'b1) $display("[TB] FAIL frame_done_n1: got %b, required 1", fd); else n_pass++;
      n_checks++; if (frame_cnt - f0 !== 1) $display("[TB] FAIL frame_done_count: got %0d, required 1", frame_cnt - f0); else n_pass++;
      n_checks++; if (cursor !== 5'd0) $display("[TB] FAIL frame_cursor: got %0d, required 0", cursor); else n_pass++;
      while (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         read_char(e.idx, v);
         n_checks++;
         if (v !== e.ch) $display("[TB] FAIL frame_buffer[%0d]: got %h, required %h", e.idx, v, e.ch);
         else n_pass++;
      end
   endtask

   task automatic test_busy_violation();
      logic       fd, bz;
      logic [7:0] v;
      sb_entry_t  e;
      xfer(1'b1, 1'b0, "X", 50, fd, bz);
      e.idx = int'(exp_cursor);
      e.ch  = "X";
      sb_q.push_back(e);
      exp_mem[exp_cursor] = "X";
      exp_cursor = exp_cursor + 5'd1;
      xfer(1'b1, 1'b0, "Y", 2, fd, bz);
      wait_idle();
      n_checks++; if (err !== 4'b0001) $display("[TB] FAIL busy_err: got %b, required 0001", err); else n_pass++;
      n_checks++; if (cursor !== exp_cursor) $display("[TB] FAIL busy_cursor: got %0d, required %0d", cursor, exp_cursor); else n_pass++;
      read_char(1, v);
      n_checks++; if (v !== exp_mem[1]) $display("[TB] FAIL busy_unchanged: got %h, required %h", v, exp_mem[1]); else n_pass++;
      while (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         read_char(e.idx, v);
         n_checks++;
         if (v !== e.ch) $display("[TB] FAIL busy_buffer[%0d]: got %h, required %h", e.idx, v, e.ch);
         else n_pass++;
      end
      pulse_err_clr();
      n_checks++; if (err !== 4'h0) $display("[TB] FAIL busy_err_clr: got %b, required 0000", err); else n_pass++;
   endtask

   task automatic test_short_pulse();
      logic       fd;
      logic [7:0] v;
      sb_entry_t  e;
      put_cmd(8'h83);
      exp_cursor = 5'd3;
      put_char("B", T_MIN, fd);
      n_checks++; if (err !== 4'h0) $display("[TB] FAIL pulse_min_ok: got %b, required 0000", err); else n_pass++;
      e = sb_q.pop_front();
      read_char(e.idx, v);
      n_checks++; if (v !== e.ch) $display("[TB] FAIL pulse_min_buffer[%0d]: got %h, required %h", e.idx, v, e.ch); else n_pass++;
      put_cmd(8'h83);
      exp_cursor = 5'd3;
      put_char("A", 4, fd);
      n_checks++; if (err !== 4'b0010) $display("[TB] FAIL pulse_short_err: got %b, required 0010", err); else n_pass++;
      n_checks++; if (cursor !== exp_cursor) $display("[TB] FAIL pulse_cursor: got %0d, required %0d", cursor, exp_cursor); else n_pass++;
      e = sb_q.pop_front();
      read_char(e.idx, v);
      n_checks++; if (v !== e.ch) $display("[TB] FAIL pulse_short_buffer[%0d]: got %h, required %h", e.idx, v, e.ch); else n_pass++;
      pulse_err_clr();
   endtask

   task automatic test_bad_addr();
      logic fd, bz;
      xfer(1'b0, 1'b0, 8'h95, 50, fd, bz);
      wait_idle();
      n_checks++; if (err !== 4'b0100) $display("[TB] FAIL bad_addr_err: got %b, required 0100", err); else n_pass++;
      n_checks++; if (cursor !== exp_cursor) $display("[TB] FAIL bad_addr_cursor: got %0d, required %0d", cursor, exp_cursor); else n_pass++;
      pulse_err_clr();
   endtask

   task automatic test_decrement();
      logic       fd;
      logic [7:0] v;
      sb_entry_t  e;
      put_cmd(DDRAM_LINE1);
      exp_cursor = 5'd0;
      put_cmd(8'h04);
      exp_inc = 1'b0;
      put_char("Z", 50, fd);
      n_checks++; if (fd !== 1'b0) $display("[TB] FAIL dec_no_frame: got %b, required 0", fd); else n_pass++;
      n_checks++; if (cursor !== 5'd31) $display("[TB] FAIL dec_wrap_cursor: got %0d, required 31", cursor); else n_pass++;
      put_char("Q", 50, fd);
      n_checks++; if (fd !== 1'b1) $display("[TB] FAIL dec_frame_at_31: got %b, required 1", fd); else n_pass++;
      n_checks++; if (cursor !== 5'd30) $display("[TB] FAIL dec_cursor_30: got %0d, required 30", cursor); else n_pass++;
      while (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         read_char(e.idx, v);
         n_checks++;
         if (v !== e.ch) $display("[TB] FAIL dec_buffer[%0d]: got %h, required %h", e.idx, v, e.ch);
         else n_pass++;
      end
      put_cmd(CMD_ENTRY_INC);
      exp_inc = 1'b1;
   endtask

   task automatic test_rw_violation();
      logic fd, bz;
      xfer(1'b0, 1'b1, DDRAM_LINE1, 50, fd, bz);
      wait_idle();
      n_checks++; if (bz !== 1'b0) $display("[TB] FAIL rw_no_busy: got %b, required 0", bz); else n_pass++;
      n_checks++; if (err !== 4'b1000) $display("[TB] FAIL rw_err: got %b, required 1000", err); else n_pass++;
      n_checks++; if (cursor !== exp_cursor) $display("[TB] FAIL rw_cursor: got %0d, required %0d", cursor, exp_cursor); else n_pass++;
      pulse_err_clr();
   endtask

   task automatic test_busy_length();
      logic fd, bz;
      int   n;
      xfer(1'b0, 1'b0, CMD_DISPLAY_ON, 50, fd, bz);
      n = (bz === 1'b1) ? 1 : 0;
      while (bz === 1'b1 && n < 1000) begin
         @(negedge clk);
         if (busy !== 1'b1) break;
         n++;
      end
      n_checks++; if (n !== T_STD) $display("[TB] FAIL busy_length: got %0d cycles, required %0d", n, T_STD); else n_pass++;
      wait_idle();
   endtask

   task automatic test_reset_mid_clear();
      logic       fd, bz;
      logic [7:0] v;
      xfer(1'b0, 1'b1, 8'h00, 50, fd, bz);
      wait_idle();
      xfer(1'b0, 1'b0, CMD_CLEAR, 50, fd, bz);
      read_char(31, v);
      n_checks++; if (v !== exp_mem[31]) $display("[TB] FAIL clear_partial[31]: got %h, required %h", v, exp_mem[31]); else n_pass++;
      repeat (4) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      n_checks++; if (busy !== 1'b1) $display("[TB] FAIL rst_mid_busy: got %b, required 1", busy); else n_pass++;
      n_checks++; if (cursor !== 5'd0) $display("[TB] FAIL rst_mid_cursor: got %0d, required 0", cursor); else n_pass++;
      n_checks++; if (err !== 4'h0) $display("[TB] FAIL rst_mid_err: got %b, required 0000", err); else n_pass++;
      n_checks++; if (initialized !== 1'b0) $display("[TB] FAIL rst_mid_initialized: got %b, required 0", initialized); else n_pass++;
      rst = 1'b0;
      for (int i = 0; i < 32; i++) exp_mem[i] = SPACE;
      exp_cursor = 5'd0;
      exp_inc = 1'b1;
      wait_idle();
      for (int i = 0; i < 32; i++) begin
         read_char(i, v);
         n_checks++;
         if (v !== exp_mem[i]) $display("[TB] FAIL rst_mid_buffer[%0d]: got %h, required %h", i, v, exp_mem[i]);
         else n_pass++;
      end
   endtask

   // Run every scenario in order, then report.
   initial begin
      test_reset();
      test_init();
      test_frame();
      test_busy_violation();
      test_short_pulse();
      test_bad_addr();
      test_decrement();
      test_rw_violation();
      test_busy_length();
      test_reset_mid_clear();
      repeat (5) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/lcd_responder.md
# lcd_responder

Synthesizable HD44780-style responder for the 8-bit, write-only, 2×16 character LCD bus driven by the team's LCD writer (`lcd_data`, `lcd_rs`, `lcd_rw`, `lcd_e`). It decodes the commands and data latched on each E falling edge and keeps a 32-character display buffer readable by index. It models controller busy time and flags protocol violations. It is used as the bus-functional target in simulation and as an on-FPGA loopback checker.

## Interface
- `BUSY_STD`, 2000: busy cycles after any non-clear/home command or data write.
- `BUSY_CLR`, 80000: busy cycles after clear (0x01) or home (0x02/0x03).
- `BUSY_POWERUP`, 2000000: busy cycles after reset.
- `MIN_PULSE`, 12: minimum E-high width in cycles.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `lcd_data`  in  8  bus data, same clock domain, no synchronizer.
- `lcd_rs`  in  1  0 = command, 1 = data.
- `lcd_rw`  in  1  must be 0.
- `lcd_e`  in  1  enable strobe.
- `rd_addr`  in  5  buffer index; 0–15 is line 1, 16–31 is line 2.
- `rd_char`  out  8  buffer[rd_addr], registered.
- `cursor`  out  5  current write index.
- `busy`  out  1  controller busy.
- `display_on`  out  1  D bit of the last display-control command.
- `initialized`  out  1  a function set has been accepted since reset.
- `frame_done`  out  1  one-cycle pulse when index 31 is written.
- `err_clr`  in  1  clears `err`.
- `err`  out  4  sticky flags: [0] write while busy, [1] E pulse shorter than `MIN_PULSE`, [2] invalid DDRAM address, [3] `lcd_rw`=1 access.

## Operation
- Edge detection:
  - `e_q` holds the previous `lcd_e`. Falling edge (`fall`) = `e_q & ~lcd_e`.
  - `data_q`/`rs_q`/`rw_q` are sampled every cycle while `lcd_e`=1. The values from the last high cycle are decoded.
  - `hi_cnt` counts consecutive high cycles of E and saturates.
- Acceptance checks on `fall`, in priority order:
  - `rw_q`=1: set err[3], ignore the access.
  - `busy`=1: set err[0], ignore the access.
  - `hi_cnt` < `MIN_PULSE`: set err[1], still execute the access.
- Commands (`rs_q`=0), decoded by highest set bit:
  - 0x01: clear. Enter S_CLEAR, `cursor`=0, increment mode on.
  - 0x02/0x03: `cursor`=0, busy `BUSY_CLR`.
  - 0x04–0x07: entry mode. Bit1=1 means increment, 0 means decrement. Shift bit ignored.
  - 0x08–0x0F: `display_on` = bit2.
  - 0x10–0x1F and 0x40–0x7F: accepted, no effect.
  - 0x20–0x3F: function set. Sets `initialized`.
  - 0x80–0x8F: `cursor` = low nibble.
  - 0xC0–0xCF: `cursor` = 16 + low nibble.
  - Any other value ≥0x80: set err[2], `cursor` unchanged.
  - Every accepted command except clear/home starts busy for `BUSY_STD`.
- Data (`rs_q`=1):
  - buffer[`cursor`] = `data_q`.
  - `cursor` moves ±1 modulo 32 (31→0, 0→31).
  - Busy for `BUSY_STD`.
  - Data is accepted even when `initialized`=0.
- States:
  - **S_POWERUP**: entered on reset. Fills the buffer with 0x20, one index per cycle, then waits `BUSY_POWERUP` total cycles. Goes to S_IDLE.
  - **S_IDLE**: `busy`=0. On an accepted `fall`, goes to S_EXEC or S_CLEAR.
  - **S_EXEC**: counts down the busy time, then returns to S_IDLE.
  - **S_CLEAR**: writes 0x20 to indices 0..31 on consecutive cycles, continues counting to `BUSY_CLR`, then returns to S_IDLE.
- Errors:
  - `err` bits stay set until `rst` or `err_clr`.
  - If `err_clr` and a new error occur in the same cycle, the new error bit ends up set.

## Timing
- Reset values:
  - `busy`=1, S_POWERUP.
  - `cursor`=0, `display_on`=0, `initialized`=0, increment mode on.
  - `err`=0, `frame_done`=0, `rd_char`=0x00.
- Reset during any state aborts it immediately and restarts S_POWERUP on the next cycle.
- `fall` is seen in cycle N, the first cycle `lcd_e`=0.
  - Buffer write, `cursor`, flags and `busy`=1 are all visible at N+1.
  - `busy` stays high for exactly the parameter's number of cycles, N+1 through N+BUSY.
- `frame_done` is high in cycle N+1 only.
- `rd_char` has one-cycle latency from `rd_addr`.
  - During S_CLEAR/S_POWERUP a read returns the partially cleared contents.
- A `fall` in the final busy cycle counts as a busy violation.

## Structure
- Shared package `lcd_pkg`:
  - Command codes 0x01, 0x02, 0x06, 0x0C, 0x38.
  - DDRAM bases 0x80/0xC0.
  - `SPACE`=0x20.
  - Error-bit indices.
  - State enum.
- Sub-module `lcd_ddram`: 32×8 buffer with one synchronous write port and one registered read port, shared by data writes and the clear sequencer.

## Test plan
- Reset, then writer's init 0x38,0x0C,0x01,0x06 with 50-cycle pulses and writer timing:
  - `err`=0, `initialized`=1, `display_on`=1.
  - All `rd_char`=0x20.
- 0x80, then "LOAD", 0xC0, then 16 chars ending "+00042":
  - idx 0–3 = "LOAD", idx 26–31 = "+00042".
  - `frame_done` pulses once, `cursor`=0.
- Data write 5 cycles after a previous write's `fall`:
  - err[0]=1, buffer unchanged.
  - `err_clr` → `err`=0.
- 4-cycle E pulse carrying 'A' at `cursor` 3:
  - err[1]=1, idx3='A'.
- Command 0x95:
  - err[2]=1, `cursor` unchanged.
- Entry mode 0x04 at `cursor` 0, write 'Z':
  - idx0='Z', `cursor`=31.
- `rst` asserted mid-S_CLEAR:
  - `busy`=1, `cursor`=0, `err`=0 next cycle.
  - Buffer all 0x20 after S_POWERUP.
